// File: rtl/bus_pkg.sv
// Shared definitions for the serial bus: master FSM states, transfer direction
// encodings and the default widths used by the arbiter, master and slave ports.
package bus_pkg;

  localparam int ADDR_WIDTH_DEF = 12;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int TIMEOUT_DEF    = 255;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    ADDR     = 3'd2,
    WAIT_RDY = 3'd3,
    WDATA    = 3'd4,
    RDATA    = 3'd5,
    DONE     = 3'd6,
    ABORT    = 3'd7
  } mp_state_t;

endpackage

// File: rtl/serial_shift.sv
// LSB-first shift register usable as PISO (ser_out) or SIPO (ser_in -> par_out),
// with a count of shifted bits plus last-bit and all-bits-shifted flags.
module serial_shift #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic             ser_out,
  output logic [WIDTH-1:0] par_out,
  output logic             last,
  output logic             full
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Bits leave at bit 0 and enter at the MSB, so after WIDTH shifts the first
  // received bit sits at bit 0.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (load) begin
      data_d = load_data;
      cnt_d  = '0;
    end else if (shift_en) begin
      data_d = {ser_in, data_q[WIDTH-1:1]};
      cnt_d  = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign ser_out = data_q[0];
  assign par_out = data_q;
  assign last    = (cnt_q == CW'(WIDTH - 1));
  assign full    = (cnt_q == CW'(WIDTH));

endmodule

// File: rtl/master_port.sv
// Bus master port: requests the bus, shifts address then data LSB-first to the
// slave, collects read data, and reports completion or abort with done/err.
module master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TIMEOUT    = TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  m_req,
  input  logic                  m_grant,
  output logic                  m_mode,
  output logic                  m_addr,
  output logic                  m_addr_valid,
  output logic                  m_wdata,
  output logic                  m_wdata_valid,
  input  logic                  m_rdata,
  input  logic                  m_rdata_valid,
  input  logic                  s_ready
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  mp_state_t state_q, state_d;
  logic [7:0] tmr_q, tmr_d;
  logic mode_q, mode_d;
  logic m_req_q, m_req_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic m_mode_q, m_mode_d, m_addr_q, m_addr_d, m_addr_valid_q, m_addr_valid_d;
  logic m_wdata_q, m_wdata_d, m_wdata_valid_q, m_wdata_valid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic addr_load, addr_shift, addr_ser, addr_last, addr_full;
  logic data_load, data_shift, data_ser, data_last, data_full;
  logic [ADDR_WIDTH-1:0] addr_par;
  logic [DATA_WIDTH-1:0] data_par;
  logic unused_addr_status;

  serial_shift #(.WIDTH(ADDR_WIDTH)) u_addr_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (addr_load),
    .load_data (addr),
    .shift_en  (addr_shift),
    .ser_in    (1'b0),
    .ser_out   (addr_ser),
    .par_out   (addr_par),
    .last      (addr_last),
    .full      (addr_full)
  );

  // The data register serves as PISO for writes and SIPO for reads.
  serial_shift #(.WIDTH(DATA_WIDTH)) u_data_shift (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (data_load),
    .load_data (wdata),
    .shift_en  (data_shift),
    .ser_in    (m_rdata),
    .ser_out   (data_ser),
    .par_out   (data_par),
    .last      (data_last),
    .full      (data_full)
  );

  assign unused_addr_status = ^{addr_par, addr_last};

  // Grant loss is checked before anything else in every bus-owning state.
  always_comb begin
    state_d         = state_q;
    tmr_d           = tmr_q;
    mode_d          = mode_q;
    m_req_d         = m_req_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    err_d           = 1'b0;
    rdata_d         = rdata_q;
    m_addr_d        = 1'b0;
    m_addr_valid_d  = 1'b0;
    m_wdata_d       = 1'b0;
    m_wdata_valid_d = 1'b0;
    addr_load       = 1'b0;
    addr_shift      = 1'b0;
    data_load       = 1'b0;
    data_shift      = 1'b0;
    if (done_q) busy_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !busy_q) begin
          state_d   = REQ;
          mode_d    = mode;
          m_req_d   = 1'b1;
          busy_d    = 1'b1;
          addr_load = 1'b1;
          data_load = 1'b1;
        end
      end
      REQ: begin
        if (m_grant) begin
          state_d        = ADDR;
          m_addr_d       = addr_ser;
          m_addr_valid_d = 1'b1;
          addr_shift     = 1'b1;
        end
      end
      ADDR: begin
        if (!m_grant) begin
          state_d = ABORT;
        end else if (addr_full) begin
          state_d = WAIT_RDY;
          tmr_d   = '0;
        end else begin
          m_addr_d       = addr_ser;
          m_addr_valid_d = 1'b1;
          addr_shift     = 1'b1;
        end
      end
      WAIT_RDY: begin
        if (!m_grant) begin
          state_d = ABORT;
        end else if (s_ready) begin
          if (mode_q == MODE_WRITE) begin
            state_d         = WDATA;
            m_wdata_d       = data_ser;
            m_wdata_valid_d = 1'b1;
            data_shift      = 1'b1;
          end else begin
            state_d = RDATA;
            tmr_d   = '0;
          end
        end else if (tmr_q == TMO_LAST) begin
          state_d = ABORT;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      WDATA: begin
        if (!m_grant) begin
          state_d = ABORT;
        end else if (data_full) begin
          state_d = DONE;
        end else begin
          m_wdata_d       = data_ser;
          m_wdata_valid_d = 1'b1;
          data_shift      = 1'b1;
        end
      end
      RDATA: begin
        if (!m_grant) begin
          state_d = ABORT;
        end else if (m_rdata_valid) begin
          data_shift = 1'b1;
          tmr_d      = '0;
          if (data_last) state_d = DONE;
        end else if (tmr_q == TMO_LAST) begin
          state_d = ABORT;
        end else begin
          tmr_d = tmr_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
        m_req_d = 1'b0;
        if (mode_q == MODE_READ) rdata_d = data_par;
      end
      ABORT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        err_d   = 1'b1;
        m_req_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    m_mode_d = m_addr_valid_d ? mode_q : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      tmr_q           <= '0;
      mode_q          <= 1'b0;
      m_req_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      rdata_q         <= '0;
      m_mode_q        <= 1'b0;
      m_addr_q        <= 1'b0;
      m_addr_valid_q  <= 1'b0;
      m_wdata_q       <= 1'b0;
      m_wdata_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      tmr_q           <= tmr_d;
      mode_q          <= mode_d;
      m_req_q         <= m_req_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
      rdata_q         <= rdata_d;
      m_mode_q        <= m_mode_d;
      m_addr_q        <= m_addr_d;
      m_addr_valid_q  <= m_addr_valid_d;
      m_wdata_q       <= m_wdata_d;
      m_wdata_valid_q <= m_wdata_valid_d;
    end
  end

  assign rdata         = rdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign m_req         = m_req_q;
  assign m_mode        = m_mode_q;
  assign m_addr        = m_addr_q;
  assign m_addr_valid  = m_addr_valid_q;
  assign m_wdata       = m_wdata_q;
  assign m_wdata_valid = m_wdata_valid_q;

endmodule

// File: doc/master_port.md
# master_port

Bus-master interface that turns a local single-beat read/write request into a serial bus transaction. It raises a request to the two-master bus arbiter, holds it until granted, and shifts address then data LSB-first to the addressed slave. For reads it shifts data back in and returns it. One instance sits between each master core (m1, m2) and the shared bus, driving the `mN_req` line and consuming the `mN_grant` line.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: address bits shifted per transaction.
- `DATA_WIDTH`, 8: data bits per beat.
- `TIMEOUT`, 255: maximum cycles spent waiting for `s_ready` before abort; 8-bit counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle local request; ignored unless `busy`=0.
- `mode` in 1: 1=write, 0=read; sampled with `start`.
- `addr` in ADDR_WIDTH: target address; sampled with `start`.
- `wdata` in DATA_WIDTH: write data; sampled with `start`.
- `rdata` out DATA_WIDTH: read result; valid when `done`=1, `err`=0, `mode` was read; holds until the next read completes.
- `busy` out 1: high from the cycle after `start` is accepted until the cycle after `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; 1 = aborted.
- `m_req` out 1: bus request to arbiter.
- `m_grant` in 1: grant from arbiter.
- `m_mode` out 1: transaction direction, valid while `m_addr_valid`=1.
- `m_addr` out 1: serial address bit.
- `m_addr_valid` out 1: address bit qualifier.
- `m_wdata` out 1: serial write data bit.
- `m_wdata_valid` out 1: write data qualifier.
- `m_rdata` in 1: serial read data bit from slave.
- `m_rdata_valid` in 1: read data qualifier.
- `s_ready` in 1: slave ready for the data phase.

## Operation
- All outputs registered. Reset value is 0 for every output, `rdata` included. State resets to IDLE and counters clear.
- FSM states and transitions:
  - IDLE: on `start`, latch mode/addr/wdata, assert `m_req` → REQ.
  - REQ: hold `m_req`. On `m_grant`=1, clear bit counter → ADDR.
  - ADDR: drive `m_addr`=addr[cnt], `m_addr_valid`=1, `m_mode` for exactly ADDR_WIDTH cycles, cnt 0..ADDR_WIDTH-1. Then → WAIT_RDY.
  - WAIT_RDY: count cycles. On `s_ready`=1, go to WDATA (write) or RDATA (read). If the count reaches TIMEOUT → ABORT.
  - WDATA: drive wdata[cnt] with `m_wdata_valid`=1 for DATA_WIDTH cycles → DONE.
  - RDATA: on each cycle with `m_rdata_valid`=1, store the bit at rdata[cnt] and increment cnt. Gaps are allowed and are also timed by TIMEOUT. After DATA_WIDTH bits → DONE.
  - DONE: `done`=1, `err`=0, `m_req`=0 → IDLE.
  - ABORT: `done`=1, `err`=1, `m_req`=0 → IDLE. `rdata` is left unchanged.
- Grant loss: `m_grant`=0 in ADDR, WAIT_RDY, WDATA or RDATA → ABORT next cycle. All bus valids drop in that same cycle.
- `start` while `busy`=1 is dropped; no queueing.
- `m_req` stays high continuously from REQ through the last data bit. A request is never re-raised within the same transaction.
- Asynchronous reset mid-transaction: all outputs go to 0 immediately, so the arbiter sees `m_req` fall. No `done` pulse.

## Timing
- `start` sampled at edge 0. `m_req`=1 and `busy`=1 after edge 0.
- `m_grant` first seen high at edge g. The first address bit is valid after edge g, and the last after edge g+ADDR_WIDTH-1.
- Write latency with immediate `s_ready`: `done` rises ADDR_WIDTH+DATA_WIDTH+2 cycles after the grant edge. This is the WAIT_RDY cycle plus the DONE transition.
- `m_req` falls the same edge `done` rises. The arbiter may regrant the other master on the next edge.
- `busy` falls one cycle after `done`. A new `start` is accepted in the cycle `done` is low again.

## Structure
- `bus_pkg`: state enum `mp_state_t` (IDLE, REQ, ADDR, WAIT_RDY, WDATA, RDATA, DONE, ABORT), `MODE_READ`/`MODE_WRITE` constants, default widths shared with arbiter and slave port.
- One sub-module: `serial_shift`, a parameterised PISO/SIPO shift register with bit counter and last-bit flag. Instantiated once for address and once for data.

## Test plan
- Reset: hold `rst_n`=0 → all outputs 0. Release, idle 5 cycles → `m_req`=0, `busy`=0.
- Write, addr=0xA5C, wdata=0x3C, grant 2 cycles after req, `s_ready` already high → `m_addr` bits 0,0,1,1,1,0,1,0,0,1,0,1 then `m_wdata` 0,0,1,1,1,1,0,0. `done`=1, `err`=0 at grant+22.
- Read, addr=0x001, slave returns 0x96 with one-cycle gap after bit 3 → `rdata`=0x96, `done` one cycle after 8th valid bit.
- Grant withdrawn at address bit 5 → valids drop. `done`=1, `err`=1 next cycle. `m_req`=0.
- `s_ready` never asserted → after 255 WAIT_RDY cycles `done`=1, `err`=1. `start` pulsed while busy is ignored.
- Two instances plus arbiter, both start same cycle → m1 completes first, then m2 is granted after m1 drops `m_req`. No overlapping valids.
